// File: rtl/latch_arb_pkg.sv
// Shared types and constants for the latch write arbiter: FSM state encoding,
// default strobe/gap lengths and the sizing rule for the shared down-counter.
package latch_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2,
        CLEAR  = 2'd3
    } arb_state_t;

    localparam int DEF_PULSE_W = 2;
    localparam int DEF_GAP_W   = 1;

    // Counter holds values 0..max(pulse_w, gap_w)-1; never narrower than one bit.
    function automatic int cnt_width(input int pulse_w, input int gap_w);
        int m;
        m = (pulse_w > gap_w) ? pulse_w : gap_w;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A tie goes to the requester not granted last;
// the pointer moves only when the parent accepts the offered grant.
module rr_arb2 (
    input  logic       Clk,
    input  logic       RESETn,
    input  logic [1:0] i_req,
    input  logic [1:0] i_mask,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    logic       r_prefer_b;
    logic [1:0] w_req;

    assign w_req = i_req & ~i_mask;

    always_comb begin
        o_grant = w_req;
        if (w_req == 2'b11) begin
            o_grant = r_prefer_b ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge Clk) begin
        if (!RESETn) begin
            r_prefer_b <= 1'b0;
        end else if (i_accept && (o_grant != 2'b00)) begin
            r_prefer_b <= o_grant[0];
        end
    end

endmodule

// File: rtl/latch_write_arbiter.sv
// Shares a bank of Cen-clocked octal latches between two requesters: arbitrates,
// shapes each Cen pulse with a guaranteed low gap, and sequences a bank clear.
module latch_write_arbiter
    import latch_arb_pkg::*;
#(
    parameter int NLATCH  = 4,
    parameter int AW      = $clog2(NLATCH),
    parameter int PULSE_W = DEF_PULSE_W,
    parameter int GAP_W   = DEF_GAP_W
) (
    input  logic              Clk,
    input  logic              RESETn,
    input  logic              req_a,
    input  logic [AW-1:0]     addr_a,
    input  logic [7:0]        data_a,
    input  logic              req_b,
    input  logic [AW-1:0]     addr_b,
    input  logic [7:0]        data_b,
    output logic              ack_a,
    output logic              ack_b,
    input  logic              clr_req,
    output logic [NLATCH-1:0] lat_cen,
    output logic [7:0]        lat_d,
    output logic              lat_clrn,
    output logic              busy
);

    localparam int CW = cnt_width(PULSE_W, GAP_W);

    arb_state_t        r_state, r_state_next;
    logic [CW-1:0]     r_cnt, r_cnt_next;
    logic [NLATCH-1:0] r_cen, r_cen_next;
    logic [7:0]        r_data, r_data_next;
    logic              r_clrn, r_clrn_next;
    logic              r_ack_a, r_ack_a_next;
    logic              r_ack_b, r_ack_b_next;
    logic              r_busy, r_busy_next;
    logic              r_clr_pend, r_clr_pend_next;
    logic              r_gsel_b, r_gsel_b_next;

    logic [1:0]        w_grant;
    logic              w_accept;
    logic [AW-1:0]     w_gnt_addr;
    logic [7:0]        w_gnt_data;
    logic [NLATCH-1:0] w_dec;

    rr_arb2 u_rr (
        .Clk      (Clk),
        .RESETn   (RESETn),
        .i_req    ({req_b, req_a}),
        .i_mask   ({r_ack_b, r_ack_a}),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    assign w_gnt_addr = w_grant[1] ? addr_b : addr_a;
    assign w_gnt_data = w_grant[1] ? data_b : data_a;

    // Out-of-range addresses match no bit, so such a write raises no Cen.
    generate
        for (genvar gi = 0; gi < NLATCH; gi++) begin : g_dec
            assign w_dec[gi] = (w_gnt_addr == AW'(gi));
        end
    endgenerate

    always_comb begin
        r_state_next    = r_state;
        r_cnt_next      = r_cnt;
        r_cen_next      = r_cen;
        r_data_next     = r_data;
        r_clrn_next     = 1'b1;
        r_ack_a_next    = 1'b0;
        r_ack_b_next    = 1'b0;
        r_clr_pend_next = r_clr_pend | clr_req;
        r_gsel_b_next   = r_gsel_b;
        w_accept        = 1'b0;

        case (r_state)
            IDLE: begin
                if (r_clr_pend || clr_req) begin
                    r_state_next    = CLEAR;
                    r_clrn_next     = 1'b0;
                    r_clr_pend_next = 1'b0;
                end else if (w_grant != 2'b00) begin
                    w_accept      = 1'b1;
                    r_state_next  = STROBE;
                    r_cnt_next    = CW'(PULSE_W - 1);
                    r_cen_next    = w_dec;
                    r_data_next   = w_gnt_data;
                    r_gsel_b_next = w_grant[1];
                end
            end
            STROBE: begin
                if (r_cnt == '0) begin
                    r_state_next = GAP;
                    r_cnt_next   = CW'(GAP_W - 1);
                    r_cen_next   = '0;
                end else begin
                    r_cnt_next = r_cnt - 1'b1;
                end
            end
            GAP: begin
                if (r_cnt == '0) begin
                    r_state_next = IDLE;
                    r_ack_a_next = ~r_gsel_b;
                    r_ack_b_next = r_gsel_b;
                end else begin
                    r_cnt_next = r_cnt - 1'b1;
                end
            end
            CLEAR: begin
                // Only a fresh pulse arriving during the clear cycle stays pending.
                r_state_next    = IDLE;
                r_clr_pend_next = clr_req;
            end
            default: begin
                r_state_next = IDLE;
                r_cen_next   = '0;
            end
        endcase

        r_busy_next = (r_state_next != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!RESETn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_cen      <= '0;
            r_data     <= '0;
            r_clrn     <= 1'b1;
            r_ack_a    <= 1'b0;
            r_ack_b    <= 1'b0;
            r_busy     <= 1'b0;
            r_clr_pend <= 1'b0;
            r_gsel_b   <= 1'b0;
        end else begin
            r_state    <= r_state_next;
            r_cnt      <= r_cnt_next;
            r_cen      <= r_cen_next;
            r_data     <= r_data_next;
            r_clrn     <= r_clrn_next;
            r_ack_a    <= r_ack_a_next;
            r_ack_b    <= r_ack_b_next;
            r_busy     <= r_busy_next;
            r_clr_pend <= r_clr_pend_next;
            r_gsel_b   <= r_gsel_b_next;
        end
    end

    assign lat_cen  = r_cen;
    assign lat_d    = r_data;
    assign lat_clrn = r_clrn;
    assign ack_a    = r_ack_a;
    assign ack_b    = r_ack_b;
    assign busy     = r_busy;

endmodule

// File: doc/latch_write_arbiter.md
# latch_write_arbiter

Write sequencer that shares a bank of NLATCH octal positive-edge latches (Cen rising-edge capture, synchronous CLRn) between two CPU-side requesters, A (main CPU) and B (sub CPU / DMA). It arbitrates round-robin and drives one shared 8-bit data bus plus one Cen per latch. Each Cen pulse is shaped with a guaranteed low gap, so every write yields exactly one capture edge. It also sequences a bank-wide clear.

## Interface
- NLATCH, 4: number of latches driven, 2..8
- AW, $clog2(NLATCH): address width
- PULSE_W, 2: Cen high cycles per write, >=1
- GAP_W, 1: minimum Cen low cycles after each pulse, >=1
- Clk  in  1  system clock
- RESETn  in  1  reset, synchronous, active-low; clock Clk
- req_a / req_b  in  1  write request, level; held until ack
- addr_a / addr_b  in  AW  target latch index, stable while req
- data_a / data_b  in  8  write data, stable while req
- ack_a / ack_b  out  1  one-cycle completion pulse
- clr_req  in  1  one-cycle pulse requesting a clear of all latches
- lat_cen  out  NLATCH  per-latch clock enable, one-hot or zero
- lat_d  out  8  shared latch data bus
- lat_clrn  out  1  shared latch clear, active-low
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, STROBE, GAP, CLEAR. All outputs are registered.
- IDLE transitions, in priority order:
  - If a clear is pending, go to CLEAR. Clear has priority over pending writes.
  - Otherwise, if any unmasked request is present, grant one. The grant captures the granted addr and data into internal registers, goes to STROBE, and updates the round-robin pointer.
- Round-robin: with both requesting, the requester not granted last wins. After reset, A wins the first tie.
- STROBE: lat_cen[addr]=1 and lat_d=captured data for PULSE_W cycles, then go to GAP.
- GAP: lat_cen=0, lat_d held, for GAP_W cycles. Then return to IDLE and pulse ack of the granted requester for one cycle.
- Requester mask: in the cycle ack_x is high, req_x is ignored by arbitration. This prevents a double write while the requester is dropping req.
- Address >= NLATCH (non-power-of-2 NLATCH): no Cen is raised. The write still occupies STROBE+GAP timing and is acked normally.
- clr_req arriving during STROBE/GAP is stored in a pending flag; a second pulse while pending merges into the first.
- CLEAR: lat_clrn=0 for exactly 1 cycle, lat_cen=0, then IDLE. No ack is issued; the pending flag is cleared.
- Reset values: lat_cen=0, lat_d=0, lat_clrn=1, ack_a=ack_b=0, busy=0, state IDLE, pointer favors A, clear-pending=0.
- Reset mid-operation (any state): lat_cen returns to 0 on the next edge. The in-flight write is dropped with no ack. Requesters must re-request.

## Timing
- Write request high in IDLE at cycle t:
  - lat_cen high in cycles t+1 .. t+PULSE_W.
  - The latch captures at the edge ending t+1; Q is visible at t+2.
  - ack high at cycle t+1+PULSE_W+GAP_W (defaults: t+4).
- The other requester, if waiting, is granted in the ack cycle. Its lat_cen rises at ack+1, so Cen low time is GAP_W cycles minimum.
- The same requester re-requesting is granted at ack+1 at the earliest.
- clr_req at t in IDLE: lat_clrn low in cycle t+1, IDLE again at t+2.
- clr_req and req in the same IDLE cycle: clear first. The write is granted at t+2, with lat_cen high at t+3.
- lat_d changes only on grant; it is never changed while any lat_cen is high.
- Worst-case wait for a requester: one write + one clear + own write.

## Structure
- Package latch_arb_pkg holds:
  - state enum: IDLE, STROBE, GAP, CLEAR
  - default constants for PULSE_W and GAP_W
  - a function computing the counter width from max(PULSE_W, GAP_W)
- A single down-counter is shared by STROBE and GAP.
- Sub-module rr_arb2: 2-way round-robin arbiter with a mask input and a last-grant pointer, updated only on an accepted grant.
- The top level holds the FSM, capture registers, clear-pending flag, one-hot address decode and output registers.

## Test plan
- Single write: req_a, addr_a=2, data_a=8'hA5 at t.
  - lat_cen=4'b0100 during t+1..t+2, lat_d=8'hA5.
  - ack_a at t+4; the latch model's Q[2]=8'hA5 from t+2.
- Contention: req_a and req_b asserted together, both held.
  - A is acked first; B's Cen rises one cycle after ack_a.
  - The next tie goes to B. Each latch sees exactly one rising Cen.
- Back-to-back: req_a held high across ack_a.
  - The second write starts at ack+1, not in the ack cycle.
  - Two captures total, with lat_cen low for >=1 cycle between them.
- Clear priority: clr_req and req_b in the same IDLE cycle t.
  - lat_clrn=0 only at t+1; all latch Q=0.
  - B's write follows with lat_cen high at t+3.
- Clear during write: clr_req during STROBE.
  - The write completes and is acked.
  - lat_clrn pulses in the cycle after returning to IDLE; the captured value is then cleared.
- Reset mid-STROBE: RESETn low for 1 cycle.
  - Next edge: lat_cen=0, lat_clrn=1, no ack, busy=0.
  - The pointer favors A again.
